// File: rtl/sram_pkg.sv
// Shared helpers for the banked SRAM array: byte-lane sizing and the
// elaboration-time legality check for the array parameters.
package sram_pkg;

  localparam int unsigned SRAM_BYTE_W = 8;

  typedef int unsigned be_width_t;

  function automatic be_width_t be_width(input int unsigned dw);
    return dw / SRAM_BYTE_W;
  endfunction

  function automatic bit sram_params_legal(input longint unsigned depth,
                                           input int unsigned aw,
                                           input int unsigned dw,
                                           input int unsigned lat);
    return (depth >= 64'd1) && (depth <= (64'd1 << aw)) &&
           (dw != 0) && ((dw % SRAM_BYTE_W) == 0) && (lat >= 1);
  endfunction

endpackage

// File: rtl/sram_bank_array_if.sv
// Bank request/response bundle between the AXI SRAM wrapper (master)
// and the banked array (slave).
interface sram_bank_array_if #(
  parameter int ROWS = 1,
  parameter int COLS = 1,
  parameter int AW   = 16,
  parameter int DW   = 32
);
  import sram_pkg::*;

  localparam int NB = int'(be_width(DW));

  logic [AW-1:0]                      bank_addr;
  logic [ROWS-1:0][COLS-1:0]          bank_cs;
  logic [ROWS-1:0][COLS-1:0]          bank_we;
  logic [ROWS-1:0][COLS-1:0][NB-1:0]  bank_be;
  logic [COLS-1:0][DW-1:0]            bank_wdata;
  logic [ROWS-1:0][COLS-1:0][DW-1:0]  bank_rdata;
  logic                               err_addr_o;
  logic                               err_multi_row_o;

  modport master (
    output bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
    input  bank_rdata, err_addr_o, err_multi_row_o
  );

  modport slave (
    input  bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
    output bank_rdata, err_addr_o, err_multi_row_o
  );

endinterface

// File: rtl/sram_bank.sv
// One SRAM bank: byte-enable writes, fixed-latency pipelined reads with
// output hold, and out-of-range detection on the shared word address.
module sram_bank
  import sram_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int DEPTH     = 1024,
  parameter int LAT       = 2,
  parameter int INIT_ZERO = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cs,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata,
  output logic              addr_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = DW / 8;

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_in_range;
  logic          w_wr;
  logic          w_rd;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_rd_word;

  assign w_in_range = ({1'b0, addr} < (AW+1)'(DEPTH));
  assign w_idx      = addr[IW-1:0];
  assign addr_err   = cs && !w_in_range;
  assign w_wr       = cs && we && w_in_range;
  assign w_rd       = cs && !we;
  // The array is read at sample time, so a later write never leaks into an in-flight read.
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

  if (INIT_ZERO != 0) begin : g_mem_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end else if (w_wr) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) begin
            r_mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge clk_i) begin
      if (w_wr) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) begin
            r_mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  if (LAT == 1) begin : g_lat1
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata <= '0;
      end else if (w_rd) begin
        rdata <= w_rd_word;
      end
    end
  end else begin : g_latn
    // LAT-1 stages: stage 0 captures at the sample edge, rdata loads from the last stage.
    logic [DW-1:0]  r_pipe_data [LAT-1];
    logic [LAT-2:0] r_pipe_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pipe_vld <= '0;
        for (int i = 0; i < LAT-1; i++) begin
          r_pipe_data[i] <= '0;
        end
        rdata <= '0;
      end else begin
        r_pipe_vld[0]  <= w_rd;
        r_pipe_data[0] <= w_rd_word;
        for (int i = 1; i < LAT-1; i++) begin
          r_pipe_vld[i]  <= r_pipe_vld[i-1];
          r_pipe_data[i] <= r_pipe_data[i-1];
        end
        if (r_pipe_vld[LAT-2]) begin
          rdata <= r_pipe_data[LAT-2];
        end
      end
    end
  end

endmodule

// File: rtl/sram_bank_array.sv
// ROWS x COLS grid of sram_bank instances on one shared address bus, with
// sticky out-of-range and multi-row-select protocol error flags.
module sram_bank_array
  import sram_pkg::*;
#(
  parameter int SRAM_BANKS_ROWS      = 1,
  parameter int SRAM_BANKS_COLS      = 1,
  parameter int SRAM_BANK_ADDR_WIDTH = 16,
  parameter int SRAM_BANK_DATA_WIDTH = 32,
  parameter int SRAM_BANK_DEPTH      = 1024,
  parameter int SRAM_READ_LATENCY    = 2,
  parameter int INIT_ZERO            = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  sram_bank_array_if.slave   bus
);

  localparam int ROWS = SRAM_BANKS_ROWS;
  localparam int COLS = SRAM_BANKS_COLS;
  localparam int DW   = SRAM_BANK_DATA_WIDTH;

  if (!sram_params_legal(longint'(SRAM_BANK_DEPTH), SRAM_BANK_ADDR_WIDTH,
                         SRAM_BANK_DATA_WIDTH, SRAM_READ_LATENCY)) begin : g_illegal
    $error("sram_bank_array: illegal parameter combination");
  end

  logic [ROWS-1:0][COLS-1:0]         w_addr_err;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] w_rdata;
  logic                              w_multi_row;
  logic                              r_err_addr;
  logic                              r_err_multi_row;

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      sram_bank #(
        .AW        (SRAM_BANK_ADDR_WIDTH),
        .DW        (DW),
        .DEPTH     (SRAM_BANK_DEPTH),
        .LAT       (SRAM_READ_LATENCY),
        .INIT_ZERO (INIT_ZERO)
      ) u_bank (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .cs       (bus.bank_cs[gr][gc]),
        .we       (bus.bank_we[gr][gc]),
        .be       (bus.bank_be[gr][gc]),
        .addr     (bus.bank_addr),
        .wdata    (bus.bank_wdata[gc]),
        .rdata    (w_rdata[gr][gc]),
        .addr_err (w_addr_err[gr][gc])
      );
    end
  end

  // Rows share write data per column, so two selected rows in one column is a wrapper bug.
  always_comb begin
    w_multi_row = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      logic w_seen;
      w_seen = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        if (bus.bank_cs[r][c]) begin
          if (w_seen) begin
            w_multi_row = 1'b1;
          end
          w_seen = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_addr      <= 1'b0;
      r_err_multi_row <= 1'b0;
    end else begin
      r_err_addr      <= r_err_addr | (|w_addr_err);
      r_err_multi_row <= r_err_multi_row | w_multi_row;
    end
  end

  assign bus.bank_rdata      = w_rdata;
  assign bus.err_addr_o      = r_err_addr;
  assign bus.err_multi_row_o = r_err_multi_row;

endmodule
